demux1x2_stream: RTL and testbench
==================================

# demux1x2_stream

Registered 1-to-2 demultiplexer with valid/ready handshaking. It is the distribution end of the 2:1 mux path: one input stream is routed, beat by beat, to one of two output channels according to `select`. Each output has a single-entry holding register. Optional per-channel beat counters provide debug and throughput visibility.

## Interface

Parameters:
- `WIDTH`, default 8: data width of the input and both outputs.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input WIDTH: input beat payload.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block accepts the beat this cycle.
- `select` input 1: routing for the current input beat (0 → out1, 1 → out2).
- `out1_data` output WIDTH: channel 1 payload.
- `out1_valid` output 1: channel 1 holds a beat.
- `out1_ready` input 1: channel 1 consumer accepts.
- `out2_data` output WIDTH: channel 2 payload.
- `out2_valid` output 1: channel 2 holds a beat.
- `out2_ready` input 1: channel 2 consumer accepts.
- `count1` output 8: channel 1 delivered-beat counter (see Configuration).
- `count2` output 8: channel 2 delivered-beat counter (see Configuration).

## Operation

- Each channel is a 2-state FSM over its holding register:
  - EMPTY: `outN_valid`=0.
  - FULL: `outN_valid`=1.
- Channel N can accept when it is EMPTY, or when it is FULL and `outN_ready`=1 in the same cycle (pass-through refill).
- `in_ready` is combinational: the accept condition of the channel addressed by the current `select`.
- Input transfer occurs when `in_valid && in_ready`.
  - The addressed register loads `in_data` and goes or stays FULL.
  - The other channel is untouched.
- Output transfer on channel N occurs when `outN_valid && outN_ready`.
  - If there is no simultaneous load into channel N, it goes EMPTY.
  - If there is a simultaneous load, it stays FULL with the new data.
- `select` is only meaningful while `in_valid`=1. Routing is fixed at the transfer cycle.
  - `select` may change while a beat is stalled. The stalled beat is then re-evaluated against the new target.
- Channels are independent. A stalled channel blocks only beats addressed to it.
- `outN_data` holds its value while FULL and not consumed. Its value is don't-care while EMPTY, but the register retains its last value rather than clearing.
- Counters (when enabled):
  - `countN` increments by 1 on each output transfer of channel N.
  - Unsigned, 8-bit, wraps 255 → 0 with no flag.

## Timing

- Reset (asynchronous, immediate on `rst`=1):
  - `out1_valid`=0, `out2_valid`=0.
  - `out1_data`=0, `out2_data`=0.
  - `count1`=0, `count2`=0.
  - `in_ready` becomes 1 as a consequence, since both channels are EMPTY.
- Reset mid-operation: held beats are discarded; no output transfer is counted in the reset cycle.
- Latency: a beat accepted at edge k appears on `outN_data`/`outN_valid` after edge k. Minimum 1 cycle in to out.
- Throughput: 1 beat/cycle per channel when the consumer holds `outN_ready`=1.
- A valid beat is never dropped or duplicated. `outN_valid` never deasserts without an output transfer (except on reset).
- No combinational path from `in_valid` or `in_data` to any output. `in_ready` depends combinationally on `select`, `outN_valid` and `outN_ready`.

## Configuration

- Macro `DEMUX_COUNT_EN`.
  - Defined: `count1` and `count2` registers are implemented as described above.
  - Undefined: no counter registers are synthesized; `count1` and `count2` are tied to 8'd0.
- Ports exist in both builds. Routing and handshake behaviour are identical in both builds.

## Test plan

- Reset then idle:
  - Assert `rst` asynchronously mid-cycle → both `outN_valid`=0 and counts=0 immediately; `in_ready`=1.
- Basic routing:
  - Send 8'hA5 with `select`=0, then 8'h3C with `select`=1, both readies=1 → out1 shows A5 one cycle after accept, then out2 shows 3C.
  - With `DEMUX_COUNT_EN`, count1=1 and count2=1.
- Backpressure isolation:
  - Hold `out1_ready`=0 with out1 FULL (8'h11) → `in_ready`=0 for `select`=0 and 1 for `select`=1.
  - Send 8'h22 to out2 → it is delivered; out1 still holds 8'h11.
- Pass-through refill:
  - out1 FULL with 8'h01, `out1_ready`=1, input 8'h02 `select`=0 in the same cycle → `out1_valid` stays 1, data becomes 02, no bubble.
  - Stream 8'h00..8'h0F back-to-back → 16 beats in 16 cycles, in order.
- Counter wrap:
  - Deliver 256 beats on channel 2 → count2 returns to 0, count1 unchanged.
  - Without the macro → both counts read 0 throughout.
- Reset mid-stream:
  - Both channels FULL, assert `rst` → valids drop immediately with no extra transfer.
  - After release, first beat 8'hFF on channel 1 → count1=1.

Source files
------------

// File: rtl/demux1x2_stream.sv
// -----------------------------------------------------------------------------
// demux1x2_stream
//
// Purpose:
//   Registered 1-to-2 stream demultiplexer. Each input beat is steered by
//   `select` (0 -> out1, 1 -> out2) into a single-entry holding register on
//   the addressed channel. Each channel is a two-state EMPTY/FULL FSM that
//   supports pass-through refill, so a channel whose consumer keeps
//   outN_ready=1 sustains one beat per cycle.
//
// Optional feature (macro DEMUX_COUNT_EN):
//   Defined   : count1/count2 are 8-bit wrapping counters of delivered beats.
//   Undefined : no counter registers; count1/count2 are tied to 8'd0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/valid/ready   input stream (in_ready is combinational)
//   select                routing of the current input beat
//   out1_data/valid/ready channel 1 output stream (registered)
//   out2_data/valid/ready channel 2 output stream (registered)
//   count1, count2        delivered-beat counters (see macro above)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid=1 keeps its payload stable until the
// transfer; outN_valid is never withdrawn without a transfer (except reset).
//
// FSM state is held in ch1_state_q / ch2_state_q (type ch_state_e) and can be
// probed hierarchically; outN_valid is a direct decode of it.
// -----------------------------------------------------------------------------
module demux1x2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [7:0]       count1,
  output logic [7:0]       count2
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        ch1_state_q, ch1_state_d;
  ch_state_e        ch2_state_q, ch2_state_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;

  logic ch1_can_accept, ch2_can_accept;
  logic load1, load2;
  logic xfer1, xfer2;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // A FULL channel can still take a beat if it is being drained this cycle.
    ch1_can_accept = (ch1_state_q == EMPTY) || out1_ready;
    ch2_can_accept = (ch2_state_q == EMPTY) || out2_ready;

    // Only select and channel status feed in_ready; in_valid/in_data do not.
    in_ready = select ? ch2_can_accept : ch1_can_accept;

    load1 = in_valid && in_ready && !select;
    load2 = in_valid && in_ready &&  select;

    xfer1 = (ch1_state_q == FULL) && out1_ready;
    xfer2 = (ch2_state_q == FULL) && out2_ready;
  end

  // ---------------------------------------------------------------------------
  // Channel FSMs and holding registers: next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    ch1_state_d = ch1_state_q;
    ch2_state_d = ch2_state_q;
    data1_d     = data1_q;
    data2_d     = data2_q;

    // A load wins over a drain: simultaneous load + drain stays FULL.
    if (load1) begin
      ch1_state_d = FULL;
      data1_d     = in_data;
    end else if (xfer1) begin
      ch1_state_d = EMPTY;
    end

    if (load2) begin
      ch2_state_d = FULL;
      data2_d     = in_data;
    end else if (xfer2) begin
      ch2_state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch1_state_q <= EMPTY;
      ch2_state_q <= EMPTY;
      data1_q     <= '0;
      data2_q     <= '0;
    end else begin
      ch1_state_q <= ch1_state_d;
      ch2_state_q <= ch2_state_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
    end
  end

  assign out1_valid = (ch1_state_q == FULL);
  assign out2_valid = (ch2_state_q == FULL);
  // Data registers keep their last value after draining; they are only
  // cleared by reset.
  assign out1_data  = data1_q;
  assign out2_data  = data2_q;

  // ---------------------------------------------------------------------------
  // Delivered-beat counters
  // ---------------------------------------------------------------------------
`ifdef DEMUX_COUNT_EN
  logic [7:0] count1_q, count1_d;
  logic [7:0] count2_q, count2_d;

  always_comb begin
    count1_d = count1_q;
    count2_d = count2_q;
    // 8-bit natural wrap 255 -> 0.
    if (xfer1) count1_d = count1_q + 8'd1;
    if (xfer2) count2_d = count2_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count1_q <= 8'd0;
      count2_q <= 8'd0;
    end else begin
      count1_q <= count1_d;
      count2_q <= count2_d;
    end
  end

  assign count1 = count1_q;
  assign count2 = count2_q;
`else
  assign count1 = 8'd0;
  assign count2 = 8'd0;
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// -----------------------------------------------------------------------------
// tb_demux1x2_stream
//
// Directed bench for demux1x2_stream. Inputs are driven 1 time unit after a
// rising edge; registered outputs are sampled 1 time unit after the next
// rising edge, and in_ready (combinational) is sampled 1 unit after inputs
// change. Expected beat counts are tracked in exp_c1/exp_c2 and only compared
// against count1/count2 when DEMUX_COUNT_EN is defined (otherwise 0).
// -----------------------------------------------------------------------------
module tb_demux1x2_stream;

  localparam int W = 8;
`ifdef DEMUX_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         select;
  logic [W-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out2_data;
  logic         out2_valid;
  logic         out2_ready;
  logic [7:0]   count1;
  logic [7:0]   count2;

  int checks;
  int errors;
  logic [7:0] exp_c1;
  logic [7:0] exp_c2;

  demux1x2_stream #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .select     (select),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .count1     (count1),
    .count2     (count2)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    in_valid = v;
    select   = s;
    in_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; select = 1'b0; in_data = '0;
    out1_ready = 1'b0; out2_ready = 1'b0;
    exp_c1 = 8'd0; exp_c2 = 8'd0;
    #12;
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b exp 0", out1_valid); end
    checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL reset_out2_valid got %b exp 0", out2_valid); end
    checks++; if (out1_data !== 8'h00 || out2_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h/%h exp 00/00", out1_data, out2_data); end
    checks++; if (count1 !== 8'd0 || count2 !== 8'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", count1, count2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel0 got %b exp 1", in_ready); end
    select = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel1 got %b exp 1", in_ready); end
    select = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin errors++; $display("FAIL idle_valids got %b%b exp 00", out1_valid, out2_valid); end
  endtask

  task automatic test_basic_routing();
    out1_ready = 1'b1; out2_ready = 1'b1;
    drive(1'b1, 1'b0, 8'hA5);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
    step();
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'hA5) begin errors++; $display("FAIL basic_out1 got v=%b d=%h exp v=1 d=a5", out1_valid, out1_data); end
    checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL basic_out2_idle got %b exp 0", out2_valid); end
    drive(1'b1, 1'b1, 8'h3C);
    step(); exp_c1++;
    checks++; if (out2_valid !== 1'b1 || out2_data !== 8'h3C) begin errors++; $display("FAIL basic_out2 got v=%b d=%h exp v=1 d=3c", out2_valid, out2_data); end
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL basic_out1_drained got %b exp 0", out1_valid); end
    drive(1'b0, 1'b0, 8'h00);
    step(); exp_c2++;
    checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL basic_out2_drained got %b exp 0", out2_valid); end
    checks++; if (count1 !== (CNT_EN ? exp_c1 : 8'd0) || count2 !== (CNT_EN ? exp_c2 : 8'd0)) begin
      errors++; $display("FAIL basic_counts got %0d/%0d exp %0d/%0d", count1, count2, CNT_EN ? exp_c1 : 8'd0, CNT_EN ? exp_c2 : 8'd0); end
  endtask

  task automatic test_backpressure();
    out1_ready = 1'b0; out2_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h11);
    step();
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h11) begin errors++; $display("FAIL bp_out1_full got v=%b d=%h exp v=1 d=11", out1_valid, out1_data); end
    drive(1'b1, 1'b0, 8'h99);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_sel0 got %b exp 0", in_ready); end
    step();
    checks++; if (out1_data !== 8'h11 || out1_valid !== 1'b1) begin errors++; $display("FAIL bp_out1_hold got v=%b d=%h exp v=1 d=11", out1_valid, out1_data); end
    // Stalled beat re-targeted to channel 2.
    drive(1'b1, 1'b1, 8'h22);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_sel1 got %b exp 1", in_ready); end
    step();
    checks++; if (out2_valid !== 1'b1 || out2_data !== 8'h22) begin errors++; $display("FAIL bp_out2 got v=%b d=%h exp v=1 d=22", out2_valid, out2_data); end
    drive(1'b0, 1'b0, 8'h00);
    step(); exp_c2++;
    checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL bp_out2_drained got %b exp 0", out2_valid); end
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h11) begin errors++; $display("FAIL bp_out1_still got v=%b d=%h exp v=1 d=11", out1_valid, out1_data); end
  endtask

  task automatic test_pass_through();
    // out1 holds 11 here; drain it while refilling.
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h01);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pt_in_ready got %b exp 1", in_ready); end
    step(); exp_c1++;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h01) begin errors++; $display("FAIL pt_load01 got v=%b d=%h exp v=1 d=01", out1_valid, out1_data); end
    drive(1'b1, 1'b0, 8'h02);
    step(); exp_c1++;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'h02) begin errors++; $display("FAIL pt_refill02 got v=%b d=%h exp v=1 d=02", out1_valid, out1_data); end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, W'(i));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat %0d got %b exp 1", i, in_ready); end
      step(); exp_c1++;
      checks++; if (out1_valid !== 1'b1 || out1_data !== W'(i)) begin errors++; $display("FAIL stream_beat %0d got v=%b d=%h exp v=1 d=%h", i, out1_valid, out1_data, W'(i)); end
    end
    drive(1'b0, 1'b0, 8'h00);
    step(); exp_c1++;
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b exp 0", out1_valid); end
    checks++; if (out1_data !== 8'h0F) begin errors++; $display("FAIL stream_data_retained got %h exp 0f", out1_data); end
    checks++; if (count1 !== (CNT_EN ? exp_c1 : 8'd0)) begin errors++; $display("FAIL stream_count1 got %0d exp %0d", count1, CNT_EN ? exp_c1 : 8'd0); end
  endtask

  task automatic test_counter_wrap();
    // Fresh reset so the channel-2 count starts at 0.
    rst = 1'b1; #2; rst = 1'b0; #1;
    exp_c1 = 8'd0; exp_c2 = 8'd0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, W'(i));
      step();
      if (i != 0) exp_c2++;
    end
    checks++; if (count2 !== (CNT_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL wrap_count2_255 got %0d exp %0d", count2, CNT_EN ? 8'd255 : 8'd0); end
    checks++; if (out2_data !== 8'hFF) begin errors++; $display("FAIL wrap_last_data got %h exp ff", out2_data); end
    drive(1'b0, 1'b0, 8'h00);
    step(); exp_c2++;
    checks++; if (count2 !== 8'd0 || exp_c2 !== 8'd0) begin errors++; $display("FAIL wrap_count2_0 got %0d exp 0", count2); end
    checks++; if (count1 !== 8'd0) begin errors++; $display("FAIL wrap_count1 got %0d exp 0", count1); end
  endtask

  task automatic test_reset_mid_stream();
    out1_ready = 1'b0; out2_ready = 1'b0;
    drive(1'b1, 1'b0, 8'hAA);
    step();
    drive(1'b1, 1'b1, 8'hBB);
    step();
    checks++; if (out1_valid !== 1'b1 || out2_valid !== 1'b1) begin errors++; $display("FAIL mid_both_full got %b%b exp 11", out1_valid, out2_valid); end
    // Consumers become ready in the same cycle reset hits: nothing may count.
    drive(1'b0, 1'b0, 8'h00);
    out1_ready = 1'b1; out2_ready = 1'b1;
    #2; rst = 1'b1; #1;
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valids got %b%b exp 00", out1_valid, out2_valid); end
    checks++; if (out1_data !== 8'h00 || out2_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h/%h exp 00/00", out1_data, out2_data); end
    step();
    checks++; if (count1 !== 8'd0 || count2 !== 8'd0) begin errors++; $display("FAIL mid_rst_counts got %0d/%0d exp 0/0", count1, count2); end
    rst = 1'b0;
    exp_c1 = 8'd0; exp_c2 = 8'd0;
    drive(1'b1, 1'b0, 8'hFF);
    step();
    checks++; if (out1_valid !== 1'b1 || out1_data !== 8'hFF) begin errors++; $display("FAIL post_rst_ff got v=%b d=%h exp v=1 d=ff", out1_valid, out1_data); end
    drive(1'b0, 1'b0, 8'h00);
    step(); exp_c1++;
    checks++; if (count1 !== (CNT_EN ? 8'd1 : 8'd0) || count2 !== 8'd0) begin errors++; $display("FAIL post_rst_counts got %0d/%0d exp %0d/0", count1, count2, CNT_EN ? 8'd1 : 8'd0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_routing();
    test_backpressure();
    test_pass_through();
    test_counter_wrap();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
